// File: rtl/echo_capture_ctrl_if.sv
// Echo capture controller bus bundle: sample-buffer RAM port plus the
// valid/ready readout stream toward the upload path.
interface echo_capture_ctrl_if #(
    parameter int ASIZE = 13,
    parameter int DSIZE = 8
) ();
    logic             o_ram_we;
    logic [ASIZE-1:0] o_ram_wraddr;
    logic [DSIZE-1:0] o_ram_data;
    logic [ASIZE-1:0] o_ram_rdaddr;
    logic [DSIZE-1:0] i_ram_q;
    logic             o_rd_valid;
    logic [DSIZE-1:0] o_rd_data;
    logic             o_rd_last;
    logic             i_rd_ready;

    // Controller side: drives RAM addressing and the readout stream.
    modport master (
        output o_ram_we, o_ram_wraddr, o_ram_data, o_ram_rdaddr,
        input  i_ram_q,
        output o_rd_valid, o_rd_data, o_rd_last,
        input  i_rd_ready
    );

    // RAM / upload side.
    modport slave (
        input  o_ram_we, o_ram_wraddr, o_ram_data, o_ram_rdaddr,
        output i_ram_q,
        input  o_rd_valid, o_rd_data, o_rd_last,
        output i_rd_ready
    );
endinterface

// File: rtl/echo_capture_ctrl.sv
// Echo capture controller: arms, waits for the transmit trigger, writes
// len+1 ADC samples into the sample RAM, then streams them out in order
// through a 2-entry skid buffer that hides the RAM's one-cycle read latency.
module echo_capture_ctrl #(
    parameter int ASIZE = 13,
    parameter int DSIZE = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [ASIZE-1:0]    i_len,
    input  logic                i_trig,
    input  logic                i_adc_valid,
    input  logic [DSIZE-1:0]    i_adc_data,
    echo_capture_ctrl_if.master bus,
    output logic                o_busy,
    output logic                o_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_TRIG,
        S_CAPTURE,
        S_READOUT
    } state_t;

    // One extra bit so a full-depth capture/readout reaches 2^ASIZE without wrapping.
    localparam logic [ASIZE:0] CNT_ONE = {{ASIZE{1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [ASIZE-1:0] len_q, len_d;
    logic [ASIZE:0]   wr_cnt_q, wr_cnt_d;
    logic [ASIZE:0]   rd_ptr_q, rd_ptr_d;
    logic             inflight_q, inflight_d;
    logic             inflight_last_q, inflight_last_d;
    logic [1:0]       count_q, count_d;
    logic             head_q, head_d;
    logic             done_q, done_d;

    logic [DSIZE-1:0] buf_data_q [2];
    logic             buf_last_q [2];

    logic             capture;
    logic             rd_valid;
    logic             head_last;
    logic             pop;
    logic             push;
    logic             issue;
    logic             wr_slot;

    // Capture strobe, buffer handshake and read-issue decisions for this cycle.
    always_comb begin
        capture   = i_adc_valid &&
                    (((state_q == S_WAIT_TRIG) && i_trig) || (state_q == S_CAPTURE));
        rd_valid  = (count_q != 2'd0);
        head_last = buf_last_q[head_q];
        pop       = rd_valid && bus.i_rd_ready;
        push      = inflight_q;
        wr_slot   = head_q ^ count_q[0];
        // Occupancy after this cycle's pop plus the read returning now must leave a slot free.
        issue     = (state_q == S_READOUT) && !i_abort &&
                    (rd_ptr_q <= {1'b0, len_q}) &&
                    (({1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2);
    end

    // Next-state logic for the sequencer, counters and output buffer bookkeeping.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d         = state_q;
        len_d           = len_q;
        wr_cnt_d        = wr_cnt_q;
        rd_ptr_d        = rd_ptr_q;
        inflight_d      = issue;
        inflight_last_d = (rd_ptr_q == {1'b0, len_q});
        count_d         = count_q + {1'b0, push} - {1'b0, pop};
        head_d          = head_q ^ pop;
        done_d          = 1'b0;

        case (state_q)
            S_IDLE: begin
                wr_cnt_d = '0;
                rd_ptr_d = '0;
                if (i_start && !i_abort) begin
                    len_d   = i_len;
                    state_d = S_WAIT_TRIG;
                end
            end
            S_WAIT_TRIG: begin
                if (i_trig) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
            end
            S_READOUT: begin
                if (pop && head_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (capture) begin
            wr_cnt_d = wr_cnt_q + CNT_ONE;
            if (wr_cnt_q == {1'b0, len_q}) begin
                state_d = S_READOUT;
            end
        end

        if (issue) begin
            rd_ptr_d = rd_ptr_q + CNT_ONE;
        end

        // Abort dominates: flush the buffer, drop any returning read, no done pulse.
        if (i_abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            count_d    = 2'd0;
            head_d     = 1'b0;
            inflight_d = 1'b0;
            done_d     = 1'b0;
        end
    end

    // Control registers with synchronous active-high reset.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        if (i_rst) begin
            state_q         <= S_IDLE;
            len_q           <= '0;
            wr_cnt_q        <= '0;
            rd_ptr_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            count_q         <= 2'd0;
            head_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            len_q           <= len_d;
            wr_cnt_q        <= wr_cnt_d;
            rd_ptr_q        <= rd_ptr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            count_q         <= count_d;
            head_q          <= head_d;
            done_q          <= done_d;
        end
    end

    // Output buffer storage: RAM data lands here one cycle after the read is issued.
    always_ff @(posedge i_clk) begin
        // NOTE: storage is not reset; count_q alone decides which entries are visible.
        if (push) begin
            buf_data_q[wr_slot] <= bus.i_ram_q;
            buf_last_q[wr_slot] <= inflight_last_q;
        end
    end

    assign bus.o_ram_we     = capture;
    assign bus.o_ram_wraddr = wr_cnt_q[ASIZE-1:0];
    assign bus.o_ram_data   = capture ? i_adc_data : '0;
    assign bus.o_ram_rdaddr = rd_ptr_q[ASIZE-1:0];
    assign bus.o_rd_valid   = rd_valid;
    assign bus.o_rd_data    = rd_valid ? buf_data_q[head_q] : '0;
    assign bus.o_rd_last    = rd_valid && head_last;
    assign o_busy           = (state_q != S_IDLE);
    assign o_done           = done_q;

endmodule

// File: tb/tb_echo_capture_ctrl.sv
// Testbench for echo_capture_ctrl: randomized acquisitions checked every
// cycle against a transaction-level model, plus literal expectations for
// the directed scenarios (basic, backpressure, edge lengths, abort, reset).
module tb_echo_capture_ctrl;
    localparam int ASIZE = 4;
    localparam int DSIZE = 8;
    localparam int DEPTH = 1 << ASIZE;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort_in;
    logic [ASIZE-1:0] len_in;
    logic             trig;
    logic             adc_valid;
    logic [DSIZE-1:0] adc_data;
    logic             busy;
    logic             done;

    echo_capture_ctrl_if #(.ASIZE(ASIZE), .DSIZE(DSIZE)) bus ();

    echo_capture_ctrl #(.ASIZE(ASIZE), .DSIZE(DSIZE)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_abort     (abort_in),
        .i_len       (len_in),
        .i_trig      (trig),
        .i_adc_valid (adc_valid),
        .i_adc_data  (adc_data),
        .bus         (bus),
        .o_busy      (busy),
        .o_done      (done)
    );

    always #5 clk = ~clk;

    // Sample RAM with registered read address.
    logic [DSIZE-1:0] ram [DEPTH];
    logic [DSIZE-1:0] ram_q;
    always @(posedge clk) begin
        if (bus.o_ram_we) ram[bus.o_ram_wraddr] <= bus.o_ram_data;
        ram_q <= ram[bus.o_ram_rdaddr];
    end
    assign bus.i_ram_q = ram_q;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: phase 0 idle, 1 armed, 2 capturing, 3 reading out.
    int               m_phase = 0;
    int               m_len = 0;
    int               m_wr = 0;
    int               m_xfer = 0;
    logic [DSIZE-1:0] m_mem [DEPTH];
    bit               m_done_exp = 0;
    int               m_rd_cyc = 0;
    bit               m_ready_run = 0;
    bit               m_after_rst = 0;
    bit               prev_stall = 0;
    logic [DSIZE-1:0] prev_data;
    logic             prev_last;

    // Observation logs used by the directed literal checks.
    int               cyc = 0;
    int               hs_count = 0;
    int               done_count = 0;
    int               first_hs_cyc = 0;
    int               last_hs_cyc = 0;
    int               done_cyc = 0;
    logic [DSIZE-1:0] beats_q [$];
    bit               lasts_q [$];
    int               wr_log [$];
    int               ready_mode = 0;
    int               pat_idx = 0;
    logic [DSIZE-1:0] sdata [DEPTH];

    // Compare process: check outputs mid-cycle, then advance the model.
    always @(negedge clk) begin
        bit exp_we;
        bit hs;
        cyc++;
        if (rst) begin
            m_phase     = 0;
            m_done_exp  = 0;
            m_after_rst = 1;
            prev_stall  = 0;
        end else begin
            if (m_after_rst) begin
                check("rst_ram_we",     bus.o_ram_we,     0);
                check("rst_ram_wraddr", bus.o_ram_wraddr, 0);
                check("rst_ram_data",   bus.o_ram_data,   0);
                check("rst_ram_rdaddr", bus.o_ram_rdaddr, 0);
                check("rst_rd_valid",   bus.o_rd_valid,   0);
                check("rst_rd_data",    bus.o_rd_data,    0);
                check("rst_rd_last",    bus.o_rd_last,    0);
                check("rst_done",       done,             0);
            end
            m_after_rst = 0;

            exp_we = adc_valid && ((m_phase == 1 && trig) || m_phase == 2);
            check("busy",   busy,         m_phase != 0);
            check("ram_we", bus.o_ram_we, exp_we);
            if (exp_we) begin
                check("ram_wraddr", bus.o_ram_wraddr, m_wr);
                check("ram_data",   bus.o_ram_data,   adc_data);
                wr_log.push_back(int'(bus.o_ram_wraddr));
            end
            check("done", done, m_done_exp);
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end

            if (m_phase != 3)
                check("rd_valid_outside_readout", bus.o_rd_valid, 0);
            else if (m_ready_run)
                check("rd_valid_timing", bus.o_rd_valid, m_rd_cyc >= 2);

            if (prev_stall) begin
                check("stall_valid", bus.o_rd_valid, 1);
                check("stall_data",  bus.o_rd_data,  prev_data);
                check("stall_last",  bus.o_rd_last,  prev_last);
            end

            hs = bus.o_rd_valid && bus.i_rd_ready;
            if (hs && m_phase == 3) begin
                check("rd_data", bus.o_rd_data, m_mem[m_xfer]);
                check("rd_last", bus.o_rd_last, m_xfer == m_len);
            end
            if (hs) begin
                if (hs_count == 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
                hs_count++;
                beats_q.push_back(bus.o_rd_data);
                lasts_q.push_back(bus.o_rd_last);
            end
            prev_stall = bus.o_rd_valid && !bus.i_rd_ready;
            prev_data  = bus.o_rd_data;
            prev_last  = bus.o_rd_last;

            m_done_exp = 0;
            if (abort_in && m_phase != 0) begin
                m_phase    = 0;
                prev_stall = 0;
            end else begin
                case (m_phase)
                    0: if (start) begin
                        m_phase = 1;
                        m_len   = int'(len_in);
                        m_wr    = 0;
                        m_xfer  = 0;
                    end
                    1, 2: begin
                        if (exp_we) begin
                            m_mem[m_wr] = adc_data;
                            if (m_wr == m_len) begin
                                m_phase     = 3;
                                m_rd_cyc    = 0;
                                m_ready_run = 1;
                            end else begin
                                m_phase = 2;
                            end
                            m_wr++;
                        end else if (m_phase == 1 && trig) begin
                            m_phase = 2;
                        end
                    end
                    3: begin
                        m_ready_run = m_ready_run && bus.i_rd_ready;
                        m_rd_cyc++;
                        if (hs) begin
                            if (m_xfer == m_len) begin
                                m_phase    = 0;
                                m_done_exp = 1;
                            end
                            m_xfer++;
                        end
                    end
                    default: m_phase = 0;
                endcase
            end
        end
    end

    // Downstream ready generator.
    initial begin
        bus.i_rd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.i_rd_ready = 1'b1;
                1: begin
                    bus.i_rd_ready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
                    pat_idx++;
                end
                2: bus.i_rd_ready = 1'($urandom_range(0, 1));
                3: bus.i_rd_ready = (hs_count < 3);
                default: bus.i_rd_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        beats_q.delete();
        lasts_q.delete();
        wr_log.delete();
        hs_count   = 0;
        done_count = 0;
    endtask

    task automatic arm(input int len);
        start  = 1'b1;
        len_in = ASIZE'(len);
        tick();
        start  = 1'b0;
        len_in = ASIZE'($urandom);
    endtask

    // Trigger, then feed n samples from sdata; abort_after >= 0 aborts before that sample.
    task automatic capture(input int n, input int gap, input bit on_trig,
                           input int abort_after, input bit noise);
        int i;
        repeat ($urandom_range(0, 2)) begin
            adc_valid = 1'($urandom_range(0, 1));
            adc_data  = 8'($urandom);
            tick();
        end
        trig      = 1'b1;
        adc_valid = on_trig;
        adc_data  = sdata[0];
        tick();
        trig      = 1'b0;
        adc_valid = 1'b0;
        i = on_trig ? 1 : 0;
        while (i < n) begin
            int g;
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            repeat (g) begin
                adc_data = 8'($urandom);
                if (noise) begin
                    trig   = 1'($urandom_range(0, 1));
                    start  = 1'($urandom_range(0, 1));
                    len_in = ASIZE'($urandom);
                end
                tick();
            end
            trig  = 1'b0;
            start = 1'b0;
            if (i == abort_after) begin
                abort_in = 1'b1;
                tick();
                abort_in = 1'b0;
                return;
            end
            adc_valid = 1'b1;
            adc_data  = sdata[i];
            tick();
            adc_valid = 1'b0;
            i++;
        end
    endtask

    task automatic wait_done(input int budget);
        int seen;
        seen = 0;
        for (int k = 0; k < budget && seen == 0; k++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("done_seen", seen, 1);
        tick();
    endtask

    task automatic run_txn(input int len, input int gap, input int rmode, input bit noise);
        ready_mode = rmode;
        pat_idx    = 0;
        clear_logs();
        arm(len);
        capture(len + 1, gap, 1'b1, -1, noise);
        wait_done(600);
        check("beat_count", hs_count, len + 1);
        check("done_count", done_count, 1);
    endtask

    initial begin
        logic [DSIZE-1:0] basic_exp [4];
        basic_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst = 1'b1; start = 1'b0; abort_in = 1'b0; trig = 1'b0;
        adc_valid = 1'b0; adc_data = '0; len_in = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Trigger and samples while idle are ignored.
        trig = 1'b1; adc_valid = 1'b1; adc_data = 8'h5a;
        repeat (2) tick();
        check("idle_trig_busy", busy, 0);
        trig = 1'b0; adc_valid = 1'b0;
        tick();

        // Basic back-to-back capture, full-rate readout.
        for (int i = 0; i < 4; i++) sdata[i] = basic_exp[i];
        run_txn(3, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("basic_data", beats_q[i], basic_exp[i]);
            check("basic_last", lasts_q[i], i == 3);
            check("basic_wraddr", wr_log[i], i);
        end
        check("basic_consecutive", last_hs_cyc - first_hs_cyc, 3);
        check("basic_done_delay", done_cyc - last_hs_cyc, 1);

        // Backpressure: 1,0,0,1 pattern then random ready.
        for (int i = 0; i < DEPTH; i++) sdata[i] = 8'(i);
        run_txn(7, 0, 1, 1'b0);
        for (int i = 0; i < 8; i++) check("bp_pattern_data", beats_q[i], i);
        run_txn(7, 0, 2, 1'b0);
        for (int i = 0; i < 8; i++) check("bp_random_data", beats_q[i], i);

        // Single-sample capture in the trigger cycle.
        sdata[0] = 8'ha5;
        run_txn(0, 0, 0, 1'b0);
        check("len0_data", beats_q[0], 8'ha5);
        check("len0_last", lasts_q[0], 1);

        // Gapped samples with ignored start/trig/len noise during capture.
        for (int i = 0; i < DEPTH; i++) sdata[i] = 8'($urandom);
        run_txn(5, 3, 0, 1'b1);

        // Full depth: every address written once, no wrap.
        for (int i = 0; i < DEPTH; i++) sdata[i] = 8'(8'hf0 ^ i);
        run_txn(DEPTH - 1, 0, 2, 1'b0);
        check("full_writes", wr_log.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            check("full_wraddr", wr_log[i], i);
            check("full_ram", ram[i], 8'hf0 ^ i);
        end

        // Abort mid-capture after two samples, then a fresh capture from address 0.
        for (int i = 0; i < DEPTH; i++) sdata[i] = 8'(8'h80 + i);
        ready_mode = 0;
        clear_logs();
        arm(7);
        capture(8, 0, 1'b1, 2, 1'b0);
        check("abort_cap_busy", busy, 0);
        check("abort_cap_we", bus.o_ram_we, 0);
        repeat (3) tick();
        check("abort_cap_writes", wr_log.size(), 2);
        check("abort_cap_no_done", done_count, 0);
        for (int i = 0; i < 4; i++) sdata[i] = basic_exp[i];
        run_txn(3, 0, 0, 1'b0);
        check("post_abort_wraddr0", wr_log[0], 0);
        check("post_abort_data0", beats_q[0], 8'h11);

        // Abort mid-readout after three beats with ready low.
        for (int i = 0; i < DEPTH; i++) sdata[i] = 8'(8'h30 + i);
        clear_logs();
        ready_mode = 3;
        arm(7);
        capture(8, 0, 1'b1, -1, 1'b0);
        for (int k = 0; k < 200 && hs_count < 3; k++) @(negedge clk);
        tick();
        tick();
        check("abort_rd_stalled_valid", bus.o_rd_valid, 1);
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        check("abort_rd_valid", bus.o_rd_valid, 0);
        check("abort_rd_busy", busy, 0);
        repeat (4) tick();
        check("abort_rd_beats", hs_count, 3);
        check("abort_rd_no_done", done_count, 0);
        run_txn(2, 1, 0, 1'b0);
        check("post_abort_rd_data", beats_q[2], 8'h32);

        // Reset while a readout beat is being presented.
        clear_logs();
        ready_mode = 4;
        arm(4);
        capture(5, 0, 1'b1, -1, 1'b0);
        for (int k = 0; k < 100 && !bus.o_rd_valid; k++) @(negedge clk);
        check("rst_pre_valid", bus.o_rd_valid, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_valid", bus.o_rd_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rdaddr", bus.o_ram_rdaddr, 0);
        tick();

        // Randomized acquisitions.
        for (int t = 0; t < 6; t++) begin
            int len;
            len = int'($urandom_range(0, DEPTH - 1));
            for (int i = 0; i < DEPTH; i++) sdata[i] = 8'($urandom);
            run_txn(len, -1, 2, 1'b1);
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
